// File: rtl/btn_tx_sched_if.sv
// Button-event / UART-byte bundle shared by btn_tx_sched and its environment.
// master = the scheduler side, slave = the event source and transmitter side.
interface btn_tx_sched_if #(
    parameter int unsigned DROP_W = 8
);
    logic [3:0]        evt;
    logic              tx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              busy;
    logic [1:0]        grant_id;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        input  evt,
        input  tx_ready,
        output tx_valid,
        output tx_data,
        output busy,
        output grant_id,
        output drop_cnt
    );

    modport slave (
        output evt,
        output tx_ready,
        input  tx_valid,
        input  tx_data,
        input  busy,
        input  grant_id,
        input  drop_cnt
    );
endinterface

// File: rtl/btn_tx_sched.sv
// Latches four button events and sends each as a key byte (optionally followed by CR LF)
// to a UART transmitter, arbitrating round-robin and counting coalesced events.
module btn_tx_sched #(
    parameter int unsigned EOL_EN = 1,
    parameter int unsigned DROP_W = 8
) (
    input logic           clk,
    input logic           rst,
    btn_tx_sched_if.master bus
);
    localparam int unsigned SumW = DROP_W + 3;

    typedef enum logic [1:0] {StIdle, StKey, StCr, StLf} state_e;

    state_e            state_q, state_d;
    logic [3:0]        pend_q, pend_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        gid_q, gid_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              busy_q;

    logic              grant;
    logic              win_vld;
    logic [1:0]        win_idx;
    logic [1:0]        rr_idx;
    logic [3:0]        grant_mask;
    logic [3:0]        drop_vec;
    logic [2:0]        drop_add;
    logic [SumW-1:0]   drop_sum;

    // Round-robin search starting one past the last winner.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        rr_idx  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            rr_idx = last_q + 2'(k);
            if (!win_vld && pend_q[rr_idx]) begin
                win_vld = 1'b1;
                win_idx = rr_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_vld) begin
                    grant   = 1'b1;
                    state_d = StKey;
                end
            end
            StKey: begin
                if (bus.tx_ready) begin
                    state_d = (EOL_EN != 0) ? StCr : StIdle;
                end
            end
            StCr: begin
                if (bus.tx_ready) begin
                    state_d = StLf;
                end
            end
            StLf: begin
                if (bus.tx_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // An event for the winner in its grant cycle re-queues it rather than counting a drop.
    always_comb begin
        grant_mask = grant ? (4'b0001 << win_idx) : 4'b0000;
        drop_vec   = bus.evt & pend_q & ~grant_mask;
        pend_d     = (pend_q & ~grant_mask) | bus.evt;
        drop_add   = 3'(drop_vec[0]) + 3'(drop_vec[1]) + 3'(drop_vec[2]) + 3'(drop_vec[3]);
        drop_sum   = SumW'(drop_q) + SumW'(drop_add);
        if (|drop_sum[SumW-1:DROP_W]) begin
            drop_d = '1;
        end else begin
            drop_d = drop_sum[DROP_W-1:0];
        end
        gid_d  = grant ? win_idx : gid_q;
        last_d = grant ? win_idx : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pend_q  <= 4'b0000;
            last_q  <= 2'd3;
            gid_q   <= 2'd0;
            drop_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            gid_q   <= gid_d;
            drop_q  <= drop_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    always_comb begin
        bus.tx_data = 8'h00;
        unique case (state_q)
            StKey: begin
                unique case (gid_q)
                    2'd0:    bus.tx_data = 8'h55;
                    2'd1:    bus.tx_data = 8'h4C;
                    2'd2:    bus.tx_data = 8'h52;
                    default: bus.tx_data = 8'h44;
                endcase
            end
            StCr:    bus.tx_data = 8'h0D;
            StLf:    bus.tx_data = 8'h0A;
            default: bus.tx_data = 8'h00;
        endcase
    end

    assign bus.tx_valid = (state_q != StIdle);
    assign bus.busy     = busy_q;
    assign bus.grant_id = gid_q;
    assign bus.drop_cnt = drop_q;
endmodule

// File: tb/tb_btn_tx_sched.sv
// Drives an EOL_EN=1 and an EOL_EN=0 instance with the same stimulus and compares both
// every cycle against a message-level reference model, plus directed byte-log checks.
module tb_btn_tx_sched;
    logic clk;
    logic rst;

    btn_tx_sched_if #(.DROP_W(8)) bus1 ();
    btn_tx_sched_if #(.DROP_W(8)) bus0 ();

    btn_tx_sched #(.EOL_EN(1), .DROP_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    btn_tx_sched #(.EOL_EN(0), .DROP_W(8)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model, index 0 = EOL_EN=0 instance, 1 = EOL_EN=1 instance.
    logic [3:0] m_pend [2];
    int         m_last [2];
    int         m_gid  [2];
    int         m_drop [2];
    int         m_len  [2];
    int         m_pos  [2];
    logic [7:0] m_msg  [2][3];

    logic [7:0] log1 [$];
    logic [7:0] log0 [$];
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] key_of(input int i);
        case (i)
            0:       return 8'h55;
            1:       return 8'h4C;
            2:       return 8'h52;
            default: return 8'h44;
        endcase
    endfunction

    task automatic model_adv(input int d, input logic [3:0] e, input logic r, input logic rs);
        int w;
        int nd;
        int idx;
        logic [3:0] np;
        if (rs) begin
            m_pend[d] = 4'b0000;
            m_last[d] = 3;
            m_gid[d]  = 0;
            m_drop[d] = 0;
            m_len[d]  = 0;
            m_pos[d]  = 0;
            return;
        end
        w  = -1;
        np = m_pend[d];
        if (m_pos[d] < m_len[d]) begin
            if (r) begin
                m_pos[d]++;
                if (m_pos[d] == m_len[d]) begin
                    m_len[d] = 0;
                    m_pos[d] = 0;
                end
            end
        end else if (m_pend[d] != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                idx = (m_last[d] + k) % 4;
                if (w < 0 && m_pend[d][idx]) w = idx;
            end
            np[w]       = 1'b0;
            m_gid[d]    = w;
            m_last[d]   = w;
            m_msg[d][0] = key_of(w);
            m_msg[d][1] = 8'h0D;
            m_msg[d][2] = 8'h0A;
            m_len[d]    = (d == 1) ? 3 : 1;
            m_pos[d]    = 0;
        end
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            if (e[i] && m_pend[d][i] && i != w) nd++;
        end
        m_drop[d] = (m_drop[d] + nd > 255) ? 255 : m_drop[d] + nd;
        m_pend[d] = np | e;
    endtask

    function automatic logic [31:0] model_vec(input int d);
        logic       v;
        logic [7:0] data;
        v    = (m_pos[d] < m_len[d]);
        data = v ? m_msg[d][m_pos[d]] : 8'h00;
        return {12'h0, v, data, v, 2'(m_gid[d]), 8'(m_drop[d])};
    endfunction

    // Apply inputs for one cycle, then compare both instances on the following negedge.
    task automatic step(input logic [3:0] e, input logic r, input logic rs);
        rst           = rs;
        bus1.evt      = e;
        bus0.evt      = e;
        bus1.tx_ready = r;
        bus0.tx_ready = r;
        if (!rs && r && bus1.tx_valid === 1'b1) log1.push_back(bus1.tx_data);
        if (!rs && r && bus0.tx_valid === 1'b1) log0.push_back(bus0.tx_data);
        model_adv(0, e, r, rs);
        model_adv(1, e, r, rs);
        @(negedge clk);
        check("cyc_eol1", {12'h0, bus1.tx_valid, bus1.tx_data, bus1.busy, bus1.grant_id,
                           bus1.drop_cnt}, model_vec(1));
        check("cyc_eol0", {12'h0, bus0.tx_valid, bus0.tx_data, bus0.busy, bus0.grant_id,
                           bus0.drop_cnt}, model_vec(0));
    endtask

    task automatic do_reset();
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        log1.delete();
        log0.delete();
    endtask

    task automatic set_exp(input int n, input logic [95:0] v);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic check_log(input string tag, input bit which);
        logic [7:0] lq [$];
        if (which) lq = log1;
        else       lq = log0;
        check({tag, "_len"}, 32'(lq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < lq.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), 32'(lq[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(4'b0000, r, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [3:0] e;
        bit         found;
        rst = 1'b1;
        bus1.evt = 4'b0000; bus0.evt = 4'b0000;
        bus1.tx_ready = 1'b0; bus0.tx_ready = 1'b0;
        for (int d = 0; d < 2; d++) model_adv(d, 4'b0000, 1'b0, 1'b1);

        // Single 'U' message with line ending.
        do_reset();
        step(4'b0001, 1'b1, 1'b0);
        idle(6, 1'b1);
        set_exp(3, {8'h55, 8'h0D, 8'h0A});
        check_log("s1_u", 1'b1);
        check("s1_busy", 32'(bus1.busy), 32'd0);

        // All four at once: served U, L, R, D with no drops.
        do_reset();
        step(4'b1111, 1'b1, 1'b0);
        idle(24, 1'b1);
        set_exp(12, {8'h55, 8'h0D, 8'h0A, 8'h4C, 8'h0D, 8'h0A,
                     8'h52, 8'h0D, 8'h0A, 8'h44, 8'h0D, 8'h0A});
        check_log("s2_all", 1'b1);
        check("s2_drop", 32'(bus1.drop_cnt), 32'd0);

        // Three 'R' pulses while the transmitter is stalled on a 'U' message.
        do_reset();
        step(4'b0001, 1'b0, 1'b0);
        idle(2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0100, 1'b0, 1'b0);
            step(4'b0000, 1'b0, 1'b0);
        end
        check("s3_drop", 32'(bus1.drop_cnt), 32'd2);
        idle(16, 1'b1);
        set_exp(6, {8'h55, 8'h0D, 8'h0A, 8'h52, 8'h0D, 8'h0A});
        check_log("s3_r", 1'b1);

        // Random events against a randomly stalling transmitter.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 4; b++) e[b] = ($urandom_range(0, 7) == 0);
            step(e, 1'(($urandom_range(0, 2) != 0)), 1'b0);
        end
        idle(40, 1'b1);
        check("s4_idle", 32'(bus1.busy), 32'd0);

        // Reset while carriage return is on offer aborts the message.
        do_reset();
        step(4'b0001, 1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (bus1.tx_valid === 1'b1 && bus1.tx_data === 8'h0D) found = 1'b1;
            else step(4'b0000, 1'b1, 1'b0);
        end
        check("s5_cr_seen", 32'(found), 32'd1);
        step(4'b0000, 1'b0, 1'b1);
        check("s5_valid", 32'(bus1.tx_valid), 32'd0);
        idle(4, 1'b1);
        check("s5_quiet", 32'(bus1.busy), 32'd0);
        step(4'b0010, 1'b1, 1'b0);
        idle(6, 1'b1);
        set_exp(4, {8'h55, 8'h4C, 8'h0D, 8'h0A});
        check_log("s5_l", 1'b1);

        // Key-only instance, then saturating drop counter.
        do_reset();
        step(4'b1000, 1'b1, 1'b0);
        idle(3, 1'b1);
        step(4'b0001, 1'b1, 1'b0);
        idle(3, 1'b1);
        set_exp(2, {8'h44, 8'h55});
        check_log("s6_keys", 1'b0);
        for (int i = 0; i < 302; i++) step(4'b0001, 1'b0, 1'b0);
        check("s6_sat0", 32'(bus0.drop_cnt), 32'd255);
        check("s6_sat1", 32'(bus1.drop_cnt), 32'd255);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/btn_tx_sched.md
BTN_TX_SCHED -- requirements
Module: btn_tx_sched

Interface
REQ-001 Parameter: EOL_EN, default 1, 1 = append CR LF (0x0D 0x0A) after each key byte; 0 = key byte only.
REQ-002 Parameter: DROP_W, default 8, width of the saturating drop counter.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: evt  input  4  single-cycle button event pulses; bit0 up, bit1 left, bit2 right, bit3 down.
REQ-006 Port: tx_ready  input  1  downstream UART transmitter can accept a byte this cycle.
REQ-007 Port: tx_valid  output  1  tx_data holds a byte offered for transfer.
REQ-008 Port: tx_data  output  8  byte offered to the UART transmitter.
REQ-009 Port: busy  output  1  a message is in progress (state not IDLE).
REQ-010 Port: grant_id  output  2  index of the requester whose message is in progress; holds its last value when idle.
REQ-011 Port: drop_cnt  output  DROP_W  saturating count of coalesced (lost) events.

Function
REQ-012 Key bytes SHALL be: index 0 0x55 'U', 1 0x4C 'L', 2 0x52 'R', 3 0x44 'D'.
REQ-013 Each requester SHALL have one pending flag, set on the cycle after its evt bit is high.
REQ-014 An evt pulse for a requester whose flag is already set SHALL leave the flag set and increment drop_cnt by 1, saturating at all-ones.
REQ-015 Several drops in one cycle SHALL add one per affected requester, still saturating.
REQ-016 FSM states: IDLE, KEY, CR, LF.
REQ-017 IDLE with any pending flag set: choose a winner round-robin, clear its flag, load grant_id, go to KEY.
REQ-018 Round-robin: search order starts at last_grant+1 mod 4; last_grant resets to 3, so index 0 has first priority.
REQ-019 A new evt for the winner in the grant cycle SHALL re-set its flag, queueing a second message, with no drop counted.
REQ-020 KEY: tx_valid=1, tx_data=key byte; on tx_valid&&tx_ready go to CR if EOL_EN=1, else IDLE.
REQ-021 CR: tx_data=0x0D; on transfer go to LF. LF: tx_data=0x0A; on transfer go to IDLE.
REQ-022 tx_valid and tx_data SHALL stay stable until a transfer occurs; tx_valid SHALL never drop without a transfer.
REQ-023 tx_valid SHALL be 0 in IDLE.
REQ-024 Latency: evt pulse at cycle N gives a pending flag at N+1, grant at N+1, and tx_valid=1 at N+2.
REQ-025 After the final byte transfers, the FSM is IDLE on the next cycle and may grant on that same cycle, giving one idle tx_valid=0 cycle between messages.
REQ-026 tx_ready held low indefinitely: the FSM SHALL hold its state, and events keep latching and counting drops.
REQ-027 busy = (state != IDLE), registered alongside the state.

Reset
REQ-028 While rst=1 at a clock edge: state=IDLE, pending flags=0, last_grant=3, grant_id=0, drop_cnt=0, tx_valid=0, tx_data=0x00, busy=0.
REQ-029 Reset mid-message SHALL abort the message: tx_valid=0 the cycle after the reset edge, and no remaining bytes are sent.
REQ-030 Events coincident with rst=1 SHALL be ignored.

Verification
REQ-031 Bench SHALL cover: evt=0001 with tx_ready=1 -> bytes 0x55,0x0D,0x0A on consecutive cycles, first at N+2; busy falls after 0x0A.
REQ-032 Bench SHALL cover: evt=1111 in one cycle with tx_ready=1 -> messages in order U,L,R,D, grant_id 0,1,2,3, drop_cnt=0.
REQ-033 Bench SHALL cover: evt=0100 pulsed 3 times while tx_ready=0 -> drop_cnt=2, then after tx_ready=1 exactly one 'R' message.
REQ-034 Bench SHALL cover: tx_ready toggling randomly -> tx_data never changes while tx_valid=1 and tx_ready=0, and the byte sequence is intact.
REQ-035 Bench SHALL cover: rst pulse during CR state -> tx_valid=0 next cycle, no 0x0A sent, pending=0, and the next evt=0010 gives 'L'.
REQ-036 Bench SHALL cover: EOL_EN=0 with evt=1000 then evt=0001 -> single bytes 0x44 then 0x55; drop_cnt saturates at 255 after 300 forced drops.
